// File: rtl/shift_add_pkg.sv
// Shared constants for the shift-add multiplier datapath and its control.
// Strobe encodings are {Load, Ad, Sh}.
package shift_add_pkg;

    localparam int SHADD_N = 4;
    localparam int CNT_W   = $clog2(SHADD_N);

    // Counter width for an arbitrary operand width (at least one bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam logic [2:0] STB_NONE = 3'b000;
    localparam logic [2:0] STB_SH   = 3'b001;
    localparam logic [2:0] STB_AD   = 3'b010;
    localparam logic [2:0] STB_ADSH = 3'b011;
    localparam logic [2:0] STB_LOAD = 3'b100;

    // Encoded as {Ad, Sh}.
    typedef enum logic [1:0] {
        OP_HOLD     = 2'b00,
        OP_SHIFT    = 2'b01,
        OP_ADD      = 2'b10,
        OP_ADDSHIFT = 2'b11
    } acc_op_e;

endpackage

// File: rtl/shift_add_counter.sv
// Iteration counter for the shift-add datapath.
// Sync clear, enable, wraps modulo 2^CW, flags the final iteration (N-1).
module shift_add_counter
    import shift_add_pkg::*;
#(
    parameter int N  = SHADD_N,
    parameter int CW = cnt_w(N)
) (
    input  logic Clk,
    input  logic Rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_term
);

    logic [CW-1:0] r_cnt;

    // Count shifts; clear has priority over enable.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_term = (r_cnt == CW'(N - 1));

endmodule

// File: rtl/shift_add_datapath.sv
// Datapath of the N x N unsigned shift-add multiplier.
// Optional SHADD_PRODUCT_HOLD_EN adds Done and a held product register.
module shift_add_datapath
    import shift_add_pkg::*;
#(
    parameter int N = SHADD_N
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic           Load,
    input  logic           Ad,
    input  logic           Sh,
    input  logic [N-1:0]   Mcand,
    input  logic [N-1:0]   Mplier,
`ifdef SHADD_PRODUCT_HOLD_EN
    input  logic           Done,
`endif
    output logic           M,
    output logic           K,
    output logic [2*N-1:0] Product
);

    localparam int CW = cnt_w(N);

    logic [N-1:0] r_mc;
    logic [2*N:0] r_acc;
    logic [N:0]   w_sum;
    logic [2*N:0] w_acc_nxt;
    acc_op_e      w_op;
    logic         w_term;

    assign w_sum = {1'b0, r_acc[2*N-1:N]} + {1'b0, r_mc};

    // Next accumulator value for the add/shift strobes.
    always_comb begin
        w_op      = acc_op_e'({Ad, Sh});
        w_acc_nxt = r_acc;
        unique case (w_op)
            OP_HOLD:     w_acc_nxt = r_acc;
            OP_ADD:      w_acc_nxt = {w_sum, r_acc[N-1:0]};
            OP_SHIFT:    w_acc_nxt = {1'b0, r_acc[2*N:1]};
            OP_ADDSHIFT: w_acc_nxt = {1'b0, w_sum, r_acc[N-1:1]};
            default:     w_acc_nxt = r_acc;
        endcase
    end

    // Operand capture and accumulator update; Load overrides Ad/Sh.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_mc  <= '0;
            r_acc <= '0;
        end else if (Load) begin
            r_mc  <= Mcand;
            r_acc <= {{(N+1){1'b0}}, Mplier};
        end else begin
            r_acc <= w_acc_nxt;
        end
    end

    shift_add_counter #(
        .N  (N),
        .CW (CW)
    ) u_cnt (
        .Clk    (Clk),
        .Rst    (Rst),
        .i_clr  (Load),
        .i_en   (Sh),
        .o_term (w_term)
    );

    assign M = r_acc[0];
    assign K = w_term;

`ifdef SHADD_PRODUCT_HOLD_EN
    logic [2*N-1:0] r_pq;

    // Hold the finished product until the next capture strobe.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_pq <= '0;
        end else if (Done) begin
            r_pq <= r_acc[2*N-1:0];
        end
    end

    assign Product = r_pq;
`else
    assign Product = r_acc[2*N-1:0];
`endif

endmodule

// File: tb/tb_shift_add_datapath.sv
// Scoreboard bench for shift_add_datapath (N=4).
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_shift_add_datapath;
    import shift_add_pkg::*;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Load;
    logic       Ad;
    logic       Sh;
    logic [3:0] Mcand;
    logic [3:0] Mplier;
    logic       M;
    logic       K;
    logic [7:0] Product;
`ifdef SHADD_PRODUCT_HOLD_EN
    logic       Done;
`endif

    always #5 Clk = ~Clk;

    shift_add_datapath #(.N(4)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Load    (Load),
        .Ad      (Ad),
        .Sh      (Sh),
        .Mcand   (Mcand),
        .Mplier  (Mplier),
`ifdef SHADD_PRODUCT_HOLD_EN
        .Done    (Done),
`endif
        .M       (M),
        .K       (K),
        .Product (Product)
    );

    localparam logic [4:0] C_M   = 5'b00001;
    localparam logic [4:0] C_K   = 5'b00010;
    localparam logic [4:0] C_P   = 5'b00100;
    localparam logic [4:0] C_ACC = 5'b01000;
    localparam logic [4:0] C_CNT = 5'b10000;

    typedef struct {
        string      name;
        logic [4:0] mask;
        logic       m;
        logic       k;
        logic [7:0] p;
        logic [8:0] acc;
        logic [1:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    always @(negedge Clk) begin
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.mask[0]) begin
                checks++;
                if (M !== e.m) begin
                    errors++;
                    $display("FAIL %s M got %0b want %0b", e.name, M, e.m);
                end
            end
            if (e.mask[1]) begin
                checks++;
                if (K !== e.k) begin
                    errors++;
                    $display("FAIL %s K got %0b want %0b", e.name, K, e.k);
                end
            end
            if (e.mask[2]) begin
                checks++;
                if (Product !== e.p) begin
                    errors++;
                    $display("FAIL %s Product got %h want %h", e.name, Product, e.p);
                end
            end
            if (e.mask[3]) begin
                checks++;
                if (dut.r_acc !== e.acc) begin
                    errors++;
                    $display("FAIL %s ACC got %h want %h", e.name, dut.r_acc, e.acc);
                end
            end
            if (e.mask[4]) begin
                checks++;
                if (dut.u_cnt.r_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL %s CNT got %0d want %0d", e.name, dut.u_cnt.r_cnt, e.cnt);
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic stb(input logic [2:0] s);
        {Load, Ad, Sh} = s;
    endtask

    task automatic expect_(input string name, input logic [4:0] mask,
                           input logic m, input logic k, input logic [7:0] p,
                           input logic [8:0] acc, input logic [1:0] cnt);
        exp_t x;
        x.name = name;
        x.mask = mask;
        x.m    = m;
        x.k    = k;
        x.p    = p;
        x.acc  = acc;
        x.cnt  = cnt;
        q.push_back(x);
    endtask

    // Acts as the control FSM: load, then N x (add state, shift state).
    task automatic run_mult(input string name, input logic [3:0] mc, input logic [3:0] mp);
        Mcand  = mc;
        Mplier = mp;
        stb(STB_LOAD);
        tick();
        expect_({name, "_load"}, C_ACC | C_CNT, 0, 0, 0, {5'b0, mp}, 2'd0);
        for (int i = 0; i < 4; i++) begin
            stb(M ? STB_AD : STB_NONE);
            tick();
            stb(STB_SH);
            expect_($sformatf("%s_k%0d", name, i), C_K, 0, (i == 3), 0, 0, 0);
            tick();
        end
        stb(STB_NONE);
    endtask

    task automatic mult(input string name, input logic [3:0] mc, input logic [3:0] mp,
                        input logic [7:0] want);
        run_mult(name, mc, mp);
`ifdef SHADD_PRODUCT_HOLD_EN
        Done = 1'b1;
        tick();
        Done = 1'b0;
`endif
        expect_({name, "_prod"}, C_P | C_ACC, 0, 0, want, {1'b0, want}, 0);
        tick();
    endtask

    initial begin
        Rst    = 1'b1;
        Mcand  = '0;
        Mplier = '0;
        stb(STB_NONE);
`ifdef SHADD_PRODUCT_HOLD_EN
        Done   = 1'b0;
`endif
        tick();
        tick();
        Rst = 1'b0;
        expect_("reset", C_M | C_K | C_P | C_ACC | C_CNT, 0, 0, 8'h00, 9'h000, 2'd0);
        tick();

        mult("m13x11", 4'd13, 4'd11, 8'h8F);
        mult("m15x15", 4'd15, 4'd15, 8'hE1);
        mult("m0x9",   4'd0,  4'd9,  8'h00);

        // Direct strobes: M sequence and counter wrap.
        Mcand  = 4'd0;
        Mplier = 4'b0101;
        stb(STB_LOAD);
        tick();
        stb(STB_NONE);
        expect_("d_m0", C_M | C_CNT, 1, 0, 0, 0, 2'd0);
        stb(STB_SH);
        tick();
        expect_("d_m1", C_M | C_CNT, 0, 0, 0, 0, 2'd1);
        tick();
        expect_("d_m2", C_M | C_K | C_CNT, 1, 0, 0, 0, 2'd2);
        tick();
        expect_("d_sh3", C_K | C_CNT, 0, 1, 0, 0, 2'd3);
        tick();
        stb(STB_NONE);
        expect_("d_sh4", C_K | C_CNT | C_ACC, 0, 0, 0, 9'h000, 2'd0);
        tick();

        // Simultaneous add and shift: sum 0_1101, ACC[3:1]=101.
        Mcand  = 4'hD;
        Mplier = 4'hB;
        stb(STB_LOAD);
        tick();
        expect_("as_pre", C_ACC | C_CNT, 0, 0, 0, 9'h00B, 2'd0);
        stb(STB_ADSH);
        tick();
        stb(STB_NONE);
        expect_("as_post", C_ACC | C_CNT, 0, 0, 0, 9'h06D, 2'd1);
        tick();

        // Reset during the second shift state of 13x11.
        Mcand  = 4'd13;
        Mplier = 4'd11;
        stb(STB_LOAD);
        tick();
        stb(M ? STB_AD : STB_NONE);
        tick();
        stb(STB_SH);
        tick();
        stb(M ? STB_AD : STB_NONE);
        tick();
        stb(STB_SH);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        stb(STB_NONE);
        expect_("abort", C_M | C_K | C_P | C_ACC | C_CNT, 0, 0, 8'h00, 9'h000, 2'd0);
        tick();
        mult("m6x7", 4'd6, 4'd7, 8'h2A);

`ifdef SHADD_PRODUCT_HOLD_EN
        mult("h13x11", 4'd13, 4'd11, 8'h8F);
        run_mult("h2x3", 4'd2, 4'd3);
        expect_("hold_keep", C_P, 0, 0, 8'h8F, 0, 0);
        tick();
        Done = 1'b1;
        tick();
        Done = 1'b0;
        expect_("hold_new", C_P, 0, 0, 8'h06, 0, 0);
        tick();
`endif

        for (int i = 0; i < 4 && q.size() > 0; i++) begin
            @(negedge Clk);
            #1;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending got %0d want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
